// File: rtl/simple_pkg.sv
// ============================================================================
// simple_pkg : shared phase, opcode-class and HLT constants for the SIMPLE core
// Rev 1.0
// ============================================================================
`default_nettype none

package simple_pkg;

    localparam logic [4:0] PHASE_NONE = 5'b00000;
    localparam logic [4:0] PHASE1     = 5'b00001;
    localparam logic [4:0] PHASE2     = 5'b00010;
    localparam logic [4:0] PHASE3     = 5'b00100;
    localparam logic [4:0] PHASE4     = 5'b01000;
    localparam logic [4:0] PHASE5     = 5'b10000;

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_STORE   = 2'b01;
    localparam logic [1:0] OP_BRANCH  = 2'b10;
    localparam logic [1:0] OP_ALU     = 2'b11;

    localparam int          HLT_FIELD_HI     = 7;
    localparam int          HLT_FIELD_LO     = 4;
    localparam logic [3:0]  HLT_CODE_DEFAULT = 4'b1111;

    // True for a single set bit or all-zero (halted).
    function automatic logic is_onehot0(input logic [4:0] v);
        return (v & (v - 5'd1)) == 5'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_ring.sv
// ============================================================================
// phase_ring : 5-bit one-hot ring counter with hold and clear (clear -> 00000)
// Rev 1.0
// ============================================================================
`default_nettype none

module phase_ring
    import simple_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       hold_i,
    input  logic       clear_i,
    output logic [4:0] phase_o
);

    logic [4:0] phase_q;
    logic [4:0] phase_d;

    // An all-zero ring restarts at PHASE1 once released; corrupt codes recover at once.
    always_comb begin
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = PHASE_NONE;
        end else if (!is_onehot0(phase_q)) begin
            phase_d = PHASE1;
        end else if (!hold_i) begin
            phase_d = (phase_q == PHASE_NONE) ? PHASE1 : {phase_q[3:0], phase_q[4]};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q <= PHASE1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// phase_sequencer : 5-phase instruction-cycle controller (PC, IR, branch, HLT)
// Optional macro SINGLE_STEP_EN adds stepEnable gating of phase5 -> phase1.
// Rev 1.0
// ============================================================================
`default_nettype none

module phase_sequencer
    import simple_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_CODE = HLT_CODE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memoryData,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    input  logic        restart,
`ifdef SINGLE_STEP_EN
    input  logic        stepEnable,
`endif
    output logic [4:0]  phase,
    output logic [15:0] IRData,
    output logic [15:0] PC,
    output logic        halted
);

    logic        rst_hold_q;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        halted_q, halted_d;

    logic [4:0]  w_phase;
    logic        w_is_hlt;
    logic        w_step_ok;
    logic        w_ring_hold;
    logic        w_ring_clear;

    assign w_is_hlt = (ir_q[15:14] == OP_ALU) &&
                      (ir_q[HLT_FIELD_HI:HLT_FIELD_LO] == HLT_CODE);

`ifdef SINGLE_STEP_EN
    assign w_step_ok = stepEnable;
`else
    assign w_step_ok = 1'b1;
`endif

    phase_ring u_ring (
        .clock_i (clock),
        .reset_i (reset),
        .hold_i  (w_ring_hold),
        .clear_i (w_ring_clear),
        .phase_o (w_phase)
    );

    always_comb begin
        pc_d         = pc_q;
        ir_d         = ir_q;
        halted_d     = halted_q;
        w_ring_hold  = 1'b0;
        w_ring_clear = 1'b0;
        if (rst_hold_q) begin
            // Freeze through the edge that releases the reset synchroniser.
            w_ring_hold = 1'b1;
        end else if (halted_q) begin
            w_ring_hold = !restart;
            halted_d    = !restart;
        end else begin
            case (w_phase)
                PHASE1: pc_d = pc_q + 16'd1;
                PHASE2: ir_d = memoryData;
                PHASE5: begin
                    if (w_is_hlt) begin
                        w_ring_clear = 1'b1;
                        halted_d     = 1'b1;
                    end else if (w_step_ok) begin
                        if (branchTaken) begin
                            pc_d = branchTarget;
                        end
                    end else begin
                        w_ring_hold = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_hold_q <= 1'b1;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            halted_q   <= 1'b0;
        end else begin
            rst_hold_q <= 1'b0;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            halted_q   <= halted_d;
        end
    end

    assign phase  = w_phase;
    assign PC     = pc_q;
    assign IRData = ir_q;
    assign halted = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// tb_phase_sequencer : directed + random bench against an instruction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] memoryData = 16'h0000;
    logic        branchTaken = 1'b0;
    logic [15:0] branchTarget = 16'h0000;
    logic        restart = 1'b0;
`ifdef SINGLE_STEP_EN
    logic        stepEnable = 1'b1;
`endif
    logic [4:0]  phase;
    logic [15:0] IRData, PC;
    logic        halted;

    // Second instance exercises PC wrap from RESET_PC = FFFF.
    logic [4:0]  phase2;
    logic [15:0] IRData2, PC2;
    logic        halted2;

    logic [15:0] mem [0:65535];

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_halt;

    always #5 clock = ~clock;

    // Synchronous-read memory: address presented in phase1 returns in phase2.
    always @(posedge clock) memoryData <= mem[PC];

    phase_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .memoryData   (memoryData),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .restart      (restart),
`ifdef SINGLE_STEP_EN
        .stepEnable   (stepEnable),
`endif
        .phase        (phase),
        .IRData       (IRData),
        .PC           (PC),
        .halted       (halted)
    );

    phase_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clock        (clock),
        .reset        (reset),
        .memoryData   (16'h0000),
        .branchTaken  (1'b0),
        .branchTarget (16'h0000),
        .restart      (1'b0),
`ifdef SINGLE_STEP_EN
        .stepEnable   (1'b1),
`endif
        .phase        (phase2),
        .IRData       (IRData2),
        .PC           (PC2),
        .halted       (halted2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hlt(input logic [15:0] ir);
        return (ir[15:14] == 2'b11) && (ir[7:4] == 4'hF);
    endfunction

    // One full instruction, entered and left with phase1 (or halt) visible.
    task automatic run_instr(input logic br, input logic [15:0] tgt, input logic noise);
        logic [15:0] addr;
        check("p1_phase", {11'd0, phase}, 16'h0001);
        check("p1_pc", PC, m_pc);
        addr = m_pc;
        m_pc = m_pc + 16'd1;
        m_ir = mem[addr];
        tick();
        check("p2_phase", {11'd0, phase}, 16'h0002);
        check("p2_pc", PC, m_pc);
        tick();
        check("p3_phase", {11'd0, phase}, 16'h0004);
        check("p3_ir", IRData, m_ir);
        if (noise) begin
            branchTaken  = 1'b1;
            branchTarget = 16'($urandom);
            restart      = 1'b1;
        end
        tick();
        check("p4_phase", {11'd0, phase}, 16'h0008);
        check("p4_pc", PC, m_pc);
        tick();
        branchTaken = 1'b0;
        restart     = 1'b0;
        check("p5_phase", {11'd0, phase}, 16'h0010);
        check("p5_pc", PC, m_pc);
        branchTaken  = br;
        branchTarget = tgt;
        tick();
        branchTaken = 1'b0;
        if (model_hlt(m_ir)) begin
            m_halt = 1'b1;
            check("hlt_phase", {11'd0, phase}, 16'h0000);
            check("hlt_flag", {15'd0, halted}, 16'h0001);
            check("hlt_pc", PC, m_pc);
        end else begin
            if (br) m_pc = tgt;
            check("wb_phase", {11'd0, phase}, 16'h0001);
            check("wb_pc", PC, m_pc);
            check("wb_halted", {15'd0, halted}, 16'h0000);
        end
    endtask

    task automatic halt_wait(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("halt_phase", {11'd0, phase}, 16'h0000);
            check("halt_pc", PC, m_pc);
            check("halt_ir", IRData, m_ir);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        m_halt  = 1'b0;
        check("rst_phase", {11'd0, phase}, 16'h0001);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        check("rst_pc", PC, m_pc);
    endtask

    initial begin
        logic [15:0] v;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        m_pc = 16'h0000; m_ir = 16'h0000; m_halt = 1'b0;

        repeat (3) tick();
        check("reset_phase", {11'd0, phase}, 16'h0001);
        check("reset_pc", PC, 16'h0000);
        check("reset_ir", IRData, 16'h0000);
        check("reset_halted", {15'd0, halted}, 16'h0000);
        check("reset_pc_wrap", PC2, 16'hFFFF);

        reset = 1'b0;
        tick();
        check("sync_hold_phase", {11'd0, phase}, 16'h0001);

        run_instr(1'b0, 16'h0000, 1'b0);
        check("wrap_pc", PC2, 16'h0000);
        check("wrap_phase", {11'd0, phase2}, 16'h0001);

        run_instr(1'b0, 16'h0000, 1'b1);
        run_instr(1'b1, 16'h0040, 1'b0);

        mem[16'h0040] = 16'hC0F0;
        run_instr(1'b1, 16'h1234, 1'b0);
        halt_wait(3);

        for (int k = 0; k < 24; k++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = {2'b11, v[13:8], 4'hF, v[3:0]};
            mem[m_pc] = v;
            run_instr(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            if (m_halt) halt_wait($urandom_range(0, 4));
        end

        mem[m_pc] = 16'h0000;
        mem[16'h0004] = 16'h1234;
        run_instr(1'b1, 16'h0004, 1'b0);
        tick();
        tick();
        check("mid_p3_phase", {11'd0, phase}, 16'h0004);
        check("mid_p3_pc", PC, 16'h0005);
        check("mid_p3_ir", IRData, 16'h1234);
        #2;
        reset = 1'b1;
        #1;
        check("async_phase", {11'd0, phase}, 16'h0001);
        check("async_pc", PC, 16'h0000);
        check("async_ir", IRData, 16'h0000);
        check("async_halted", {15'd0, halted}, 16'h0000);

        tick();
        reset = 1'b0;
        m_pc  = 16'h0000;
        m_ir  = 16'h0000;
        mem[16'h0000] = 16'hC0F0;
        tick();
        run_instr(1'b0, 16'h0000, 1'b0);
        halt_wait(3);
        check("post_halt_pc", PC, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
